// File: rtl/dmem_access_unit.sv
// Purpose: serialises one MEM-stage load/store into little-endian byte transfers; loads are reassembled and sign/zero-extended.
// Latency: accept to response is N+2 cycles for loads and N+1 for stores (N = 1/2/4 bytes).
// Backpressure: req_ready_o is high only while idle, so no new request is taken until the response pulse has gone.
// Optional DMEM_MISALIGN_TRAP_EN: a misaligned half/word is answered with rsp_err_o one cycle after accept and touches no memory.
module dmem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          cnt_q;
  logic [1:0]          cnt_last;
  logic                last;
  logic                accept;
  logic                misalign;
  logic                cap_vld_q;
  logic [1:0]          cap_idx_q;
  logic [31:0]         ld_q;
  logic [31:0]         asm_dat;
  logic [31:0]         rsp_data_q;
  logic                unused_addr_bits;

  // Only the low ADDR_W address bits reach the memory.
  assign unused_addr_bits = ^req_addr_i[31:ADDR_W];

  assign accept = req_valid_i & (state == IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  assign misalign = ((req_size_i == 2'b01) & req_addr_i[0]) |
                    (req_size_i[1] & (req_addr_i[1:0] != 2'b00));
  assign rsp_err_o = (state == RESP) & err_q;

  // Error flag is decided at accept and reported with the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end
`else
  assign misalign  = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Index of the final byte: 0 for byte, 1 for half, 3 for word (size 11 is a word).
  always_comb begin
    case (size_q)
      2'b00:   cnt_last = 2'd0;
      2'b01:   cnt_last = 2'd1;
      default: cnt_last = 2'd3;
    endcase
  end
  assign last = (cnt_q == cnt_last);

  // Sign/zero extension of the assembled load value; words pass through.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sg);
    case (sz)
      2'b00:   return {{24{sg & v[7]}}, v[7:0]};
      2'b01:   return {{16{sg & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Load value so far with the byte arriving this cycle merged in.
  always_comb begin
    asm_dat = ld_q;
    if (cap_vld_q) begin
      case (cap_idx_q)
        2'd0: asm_dat[7:0]   = mem_rdata_i;
        2'd1: asm_dat[15:8]  = mem_rdata_i;
        2'd2: asm_dat[23:16] = mem_rdata_i;
        2'd3: asm_dat[31:24] = mem_rdata_i;
        default: asm_dat = ld_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs; strobes and memory bus are quiet outside XFER.
  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_nxt = misalign ? RESP : XFER;
        end
      end
      XFER: begin
        mem_addr_o = base_q + ADDR_W'(cnt_q);
        mem_re_o   = ~wr_q;
        mem_we_o   = wr_q;
        case (cnt_q)
          2'd0: mem_wdata_o = wdata_q[7:0];
          2'd1: mem_wdata_o = wdata_q[15:8];
          2'd2: mem_wdata_o = wdata_q[23:16];
          2'd3: mem_wdata_o = wdata_q[31:24];
          default: mem_wdata_o = 8'h00;
        endcase
        if (last) begin
          state_nxt = wr_q ? RESP : DRAIN;
        end
      end
      DRAIN: state_nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch at accept and byte counter during the transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q  <= '0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else if (accept) begin
      base_q  <= req_addr_i[ADDR_W-1:0];
      size_q  <= req_size_i;
      sgn_q   <= req_signed_i;
      wr_q    <= req_write_i;
      wdata_q <= req_wdata_i;
      cnt_q   <= 2'd0;
    end else if (state == XFER) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Read data returns one cycle after its strobe, so the capture slot trails the counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= 2'd0;
      ld_q      <= 32'h0;
    end else begin
      cap_vld_q <= mem_re_o;
      cap_idx_q <= cnt_q;
      if (accept) begin
        ld_q <= 32'h0;
      end else if (cap_vld_q) begin
        ld_q <= asm_dat;
      end
    end
  end

  // Response data is loaded on entry to RESP and held until the next response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_q <= 32'h0;
    end else if ((state_nxt == RESP) && (state != RESP)) begin
      rsp_data_q <= (state == DRAIN) ? extend(asm_dat, size_q, sgn_q) : 32'h0;
    end
  end
  assign rsp_data_o = rsp_data_q;

endmodule
